// File: rtl/time_set_ctrl_if.sv
// Button, live-time and load-bus signals between the time-set controller
// and the rest of the alarm clock.
interface time_set_ctrl_if;
    logic       btn_set_time;
    logic       btn_set_alarm;
    logic       btn_inc;
    logic       btn_next;
    logic       btn_cancel;
    logic [7:0] cur_hh;
    logic [7:0] cur_mm;
    logic [7:0] cur_ss;
    logic       cur_pm;
    logic [7:0] hh_load;
    logic [7:0] mm_load;
    logic [7:0] ss_load;
    logic       pm_load;
    logic       load_time;
    logic       load_alarm;
    logic       editing;
    logic [1:0] field_sel;

    modport master (
        output btn_set_time, btn_set_alarm, btn_inc, btn_next, btn_cancel,
        output cur_hh, cur_mm, cur_ss, cur_pm,
        input  hh_load, mm_load, ss_load, pm_load,
        input  load_time, load_alarm, editing, field_sel
    );

    modport slave (
        input  btn_set_time, btn_set_alarm, btn_inc, btn_next, btn_cancel,
        input  cur_hh, cur_mm, cur_ss, cur_pm,
        output hh_load, mm_load, ss_load, pm_load,
        output load_time, load_alarm, editing, field_sel
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Button-driven time/alarm setting controller: snapshots a start value, lets the
// user step through HH/MM/SS/PM with BCD increments and auto-repeat, then commits.
module time_set_ctrl #(
    parameter int unsigned REPEAT_DELAY = 500,
    parameter int unsigned REPEAT_RATE  = 100,
    parameter int unsigned TIMEOUT      = 10000
) (
    input  logic          clk,
    input  logic          reset,
    time_set_ctrl_if.slave bus
);

    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = $clog2(REP_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [RW-1:0] L_DELAY   = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] L_RATE    = RW'(REPEAT_RATE);
    localparam logic [TW-1:0] L_TO_LAST = TW'(TIMEOUT - 1);

    localparam int B_SET    = 4;
    localparam int B_ALARM  = 3;
    localparam int B_INC    = 2;
    localparam int B_NEXT   = 1;
    localparam int B_CANCEL = 0;

    typedef enum logic [2:0] {
        IDLE, EDIT_HH, EDIT_MM, EDIT_SS, EDIT_PM, COMMIT
    } state_t;

    state_t        r_state;
    logic [7:0]    r_hh, r_mm, r_ss;
    logic          r_pm;
    logic [7:0]    r_al_hh, r_al_mm, r_al_ss;
    logic          r_al_pm;
    logic          r_target;
    logic          r_load_time, r_load_alarm, r_editing;
    logic [1:0]    r_field_sel;
    logic [4:0]    r_prev_btn;
    logic [RW-1:0] r_rep_cnt;
    logic          r_rep_active, r_rep_block;
    logic [TW-1:0] r_to_cnt;

    logic [4:0]    w_btn, w_edge;
    logic          w_activity, w_rep_fire, w_inc_fire, w_timeout;

    // Hours run 01..12; anything at or past 12 folds back to 01.
    function automatic logic [7:0] incHours(input logic [7:0] v);
        if (v >= 8'h12)
            return 8'h01;
        else if (v[3:0] >= 4'h9)
            return {v[7:4] + 4'h1, 4'h0};
        else
            return {v[7:4], v[3:0] + 4'h1};
    endfunction

    function automatic logic [7:0] incSixty(input logic [7:0] v);
        if (v >= 8'h59)
            return 8'h00;
        else if (v[3:0] >= 4'h9)
            return {v[7:4] + 4'h1, 4'h0};
        else
            return {v[7:4], v[3:0] + 4'h1};
    endfunction

    assign w_btn      = {bus.btn_set_time, bus.btn_set_alarm, bus.btn_inc, bus.btn_next, bus.btn_cancel};
    assign w_edge     = w_btn & ~r_prev_btn;
    assign w_activity = (|w_edge) | bus.btn_inc;
    assign w_rep_fire = bus.btn_inc & r_prev_btn[B_INC] & ~r_rep_block &
                        (r_rep_cnt == (r_rep_active ? L_RATE : L_DELAY));
    assign w_inc_fire = w_edge[B_INC] | w_rep_fire;
    assign w_timeout  = (r_to_cnt == L_TO_LAST) & ~w_activity;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_prev_btn <= '0;
        else
            r_prev_btn <= w_btn;
    end

    // A field change (or not editing at all) blocks repeat until btn_inc is re-pressed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rep_cnt    <= '0;
            r_rep_active <= 1'b0;
            r_rep_block  <= 1'b0;
        end else if (!r_editing || w_edge[B_NEXT]) begin
            r_rep_cnt    <= '0;
            r_rep_active <= 1'b0;
            r_rep_block  <= 1'b1;
        end else if (!bus.btn_inc) begin
            r_rep_cnt    <= '0;
            r_rep_active <= 1'b0;
            r_rep_block  <= 1'b0;
        end else if (w_edge[B_INC]) begin
            r_rep_cnt    <= RW'(1);
            r_rep_active <= 1'b0;
            r_rep_block  <= 1'b0;
        end else if (!r_rep_block) begin
            if (w_rep_fire) begin
                r_rep_cnt    <= RW'(1);
                r_rep_active <= 1'b1;
            end else begin
                r_rep_cnt <= r_rep_cnt + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_to_cnt <= '0;
        else if (!r_editing || w_activity || w_timeout)
            r_to_cnt <= '0;
        else
            r_to_cnt <= r_to_cnt + TW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_hh         <= 8'h12;
            r_mm         <= 8'h00;
            r_ss         <= 8'h00;
            r_pm         <= 1'b0;
            r_al_hh      <= 8'h12;
            r_al_mm      <= 8'h00;
            r_al_ss      <= 8'h00;
            r_al_pm      <= 1'b0;
            r_target     <= 1'b0;
            r_load_time  <= 1'b0;
            r_load_alarm <= 1'b0;
            r_editing    <= 1'b0;
            r_field_sel  <= 2'd0;
        end else begin
            r_load_time  <= 1'b0;
            r_load_alarm <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_edge[B_SET]) begin
                        r_target    <= 1'b0;
                        r_hh        <= bus.cur_hh;
                        r_mm        <= bus.cur_mm;
                        r_ss        <= bus.cur_ss;
                        r_pm        <= bus.cur_pm;
                        r_state     <= EDIT_HH;
                        r_editing   <= 1'b1;
                        r_field_sel <= 2'd0;
                    end else if (w_edge[B_ALARM]) begin
                        r_target    <= 1'b1;
                        r_hh        <= r_al_hh;
                        r_mm        <= r_al_mm;
                        r_ss        <= r_al_ss;
                        r_pm        <= r_al_pm;
                        r_state     <= EDIT_HH;
                        r_editing   <= 1'b1;
                        r_field_sel <= 2'd0;
                    end
                end
                EDIT_HH, EDIT_MM, EDIT_SS, EDIT_PM: begin
                    if (w_edge[B_CANCEL] || (!w_edge[B_NEXT] && !w_inc_fire && w_timeout)) begin
                        r_state     <= IDLE;
                        r_editing   <= 1'b0;
                        r_field_sel <= 2'd0;
                    end else if (w_edge[B_NEXT]) begin
                        case (r_state)
                            EDIT_HH: begin
                                r_state     <= EDIT_MM;
                                r_field_sel <= 2'd1;
                            end
                            EDIT_MM: begin
                                r_state     <= EDIT_SS;
                                r_field_sel <= 2'd2;
                            end
                            EDIT_SS: begin
                                r_state     <= EDIT_PM;
                                r_field_sel <= 2'd3;
                            end
                            default: begin
                                r_state      <= COMMIT;
                                r_editing    <= 1'b0;
                                r_field_sel  <= 2'd0;
                                r_load_time  <= ~r_target;
                                r_load_alarm <= r_target;
                            end
                        endcase
                    end else if (w_inc_fire) begin
                        case (r_state)
                            EDIT_HH: r_hh <= incHours(r_hh);
                            EDIT_MM: r_mm <= incSixty(r_mm);
                            EDIT_SS: r_ss <= incSixty(r_ss);
                            default: r_pm <= ~r_pm;
                        endcase
                    end
                end
                COMMIT: begin
                    if (r_target) begin
                        r_al_hh <= r_hh;
                        r_al_mm <= r_mm;
                        r_al_ss <= r_ss;
                        r_al_pm <= r_pm;
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    r_editing   <= 1'b0;
                    r_field_sel <= 2'd0;
                end
            endcase
        end
    end

    assign bus.hh_load    = r_hh;
    assign bus.mm_load    = r_mm;
    assign bus.ss_load    = r_ss;
    assign bus.pm_load    = r_pm;
    assign bus.load_time  = r_load_time;
    assign bus.load_alarm = r_load_alarm;
    assign bus.editing    = r_editing;
    assign bus.field_sel  = r_field_sel;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short repeat/timeout parameters and
// hand-computed expected BCD values.
module tb_time_set_ctrl;

    localparam logic [4:0] BT_SET    = 5'b10000;
    localparam logic [4:0] BT_ALARM  = 5'b01000;
    localparam logic [4:0] BT_INC    = 5'b00100;
    localparam logic [4:0] BT_NEXT   = 5'b00010;
    localparam logic [4:0] BT_CANCEL = 5'b00001;

    logic clk = 1'b0;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;
    int   ltCount    = 0;
    int   laCount    = 0;
    int   bothCount  = 0;

    time_set_ctrl_if u_if ();

    time_set_ctrl #(
        .REPEAT_DELAY (4),
        .REPEAT_RATE  (2),
        .TIMEOUT      (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;

    // Counts commit pulses so stray or doubled pulses show up in the totals.
    always @(negedge clk) begin
        if (reset) begin
            if (u_if.load_time)  ltCount++;
            if (u_if.load_alarm) laCount++;
            if (u_if.load_time && u_if.load_alarm) bothCount++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveButtons(input logic [4:0] b);
        {u_if.btn_set_time, u_if.btn_set_alarm, u_if.btn_inc, u_if.btn_next, u_if.btn_cancel} = b;
    endtask

    task automatic applyStimulus(input logic [4:0] b);
        driveButtons(b);
        tick();
        driveButtons(5'b00000);
        tick();
    endtask

    task automatic setCur(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss, input logic pm);
        u_if.cur_hh = hh;
        u_if.cur_mm = mm;
        u_if.cur_ss = ss;
        u_if.cur_pm = pm;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkLoads(input string tag, input logic [7:0] hh, input logic [7:0] mm,
                              input logic [7:0] ss, input logic pm);
        checkOutput({tag, " time"}, {7'd0, u_if.pm_load, u_if.hh_load, u_if.mm_load, u_if.ss_load},
                    {7'd0, pm, hh, mm, ss});
    endtask

    initial begin
        reset = 1'b0;
        driveButtons(5'b00000);
        setCur(8'h00, 8'h00, 8'h00, 1'b0);
        #22;
        checkLoads("reset", 8'h12, 8'h00, 8'h00, 1'b0);
        checkOutput("reset ctl", {u_if.load_time, u_if.load_alarm, u_if.editing, u_if.field_sel}, 5'b0);
        reset = 1'b1;
        tick();

        // Full time edit from 08:31:58 AM to 10:31:59 PM.
        setCur(8'h08, 8'h31, 8'h58, 1'b0);
        applyStimulus(BT_SET);
        checkLoads("snap time", 8'h08, 8'h31, 8'h58, 1'b0);
        checkOutput("edit hh", {u_if.editing, u_if.field_sel}, 3'b100);
        applyStimulus(BT_INC);
        checkOutput("hh 09", u_if.hh_load, 8'h09);
        applyStimulus(BT_INC);
        checkOutput("hh 10", u_if.hh_load, 8'h10);
        applyStimulus(BT_NEXT);
        checkOutput("field mm", u_if.field_sel, 2'd1);
        applyStimulus(BT_NEXT);
        applyStimulus(BT_INC);
        checkOutput("ss 59", u_if.ss_load, 8'h59);
        applyStimulus(BT_NEXT);
        checkOutput("field pm", u_if.field_sel, 2'd3);
        applyStimulus(BT_INC);
        driveButtons(BT_NEXT);
        tick();
        checkOutput("commit pulse", {u_if.load_time, u_if.load_alarm, u_if.editing}, 3'b100);
        checkLoads("commit", 8'h10, 8'h31, 8'h59, 1'b1);
        driveButtons(5'b00000);
        tick();
        checkOutput("pulse ends", {u_if.load_time, u_if.load_alarm}, 2'b00);
        checkOutput("one lt pulse", ltCount, 1);
        checkLoads("hold after", 8'h10, 8'h31, 8'h59, 1'b1);

        // Reset in the middle of an edit.
        applyStimulus(BT_SET);
        applyStimulus(BT_INC);
        checkOutput("pre-reset hh", u_if.hh_load, 8'h09);
        reset = 1'b0;
        #2;
        checkLoads("mid reset", 8'h12, 8'h00, 8'h00, 1'b0);
        checkOutput("mid reset edit", {u_if.editing, u_if.field_sel}, 3'b000);
        reset = 1'b1;
        tick();
        tick();
        checkOutput("no restart", u_if.editing, 1'b0);
        checkOutput("no reset pulse", ltCount + laCount, 1);
        applyStimulus(BT_SET);
        checkOutput("restart", {u_if.editing, u_if.hh_load}, 9'h108);
        applyStimulus(BT_CANCEL);

        // Wrap-around per field from 12:59:09 PM.
        setCur(8'h12, 8'h59, 8'h09, 1'b1);
        applyStimulus(BT_SET);
        applyStimulus(BT_INC);
        checkLoads("hh wrap", 8'h01, 8'h59, 8'h09, 1'b1);
        applyStimulus(BT_NEXT);
        applyStimulus(BT_INC);
        checkLoads("mm wrap", 8'h01, 8'h00, 8'h09, 1'b1);
        applyStimulus(BT_NEXT);
        applyStimulus(BT_INC);
        checkLoads("ss 09-10", 8'h01, 8'h00, 8'h10, 1'b1);
        applyStimulus(BT_NEXT);
        applyStimulus(BT_INC);
        checkLoads("pm toggle", 8'h01, 8'h00, 8'h10, 1'b0);
        applyStimulus(BT_CANCEL);
        checkOutput("cancel idle", u_if.editing, 1'b0);
        checkOutput("cancel no pulse", ltCount, 1);
        checkLoads("cancel keeps", 8'h01, 8'h00, 8'h10, 1'b0);

        // Auto-repeat on MM: increments at edge, +4, +6, +8 cycles.
        setCur(8'h03, 8'h00, 8'h00, 1'b0);
        applyStimulus(BT_SET);
        applyStimulus(BT_NEXT);
        driveButtons(BT_INC);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("rep before delay", u_if.mm_load, 8'h01);
        tick();
        checkOutput("rep first", u_if.mm_load, 8'h02);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("rep 10 cycles", u_if.mm_load, 8'h04);
        driveButtons(5'b00000);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("rep released", u_if.mm_load, 8'h04);
        driveButtons(BT_INC);
        tick();
        driveButtons(BT_INC | BT_NEXT);
        tick();
        driveButtons(BT_INC);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("no rep new field", {u_if.field_sel, u_if.mm_load, u_if.ss_load}, {2'd2, 8'h05, 8'h00});
        driveButtons(5'b00000);
        tick();
        applyStimulus(BT_INC);
        checkOutput("ss after repress", u_if.ss_load, 8'h01);
        applyStimulus(BT_CANCEL);

        // Alarm edit to 06:30:00 AM starting from the reset shadow.
        applyStimulus(BT_ALARM);
        checkLoads("alarm snap", 8'h12, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(BT_INC);
        applyStimulus(BT_NEXT);
        for (int i = 0; i < 30; i++) applyStimulus(BT_INC);
        applyStimulus(BT_NEXT);
        applyStimulus(BT_NEXT);
        driveButtons(BT_NEXT);
        tick();
        checkOutput("alarm pulse", {u_if.load_time, u_if.load_alarm}, 2'b01);
        checkLoads("alarm commit", 8'h06, 8'h30, 8'h00, 1'b0);
        driveButtons(5'b00000);
        tick();
        checkOutput("pulse counts", {ltCount[7:0], laCount[7:0]}, 16'h0101);
        setCur(8'h11, 8'h11, 8'h11, 1'b1);
        applyStimulus(BT_ALARM);
        checkLoads("alarm shadow", 8'h06, 8'h30, 8'h00, 1'b0);
        applyStimulus(BT_CANCEL);

        // Simultaneous start edges: time wins.
        applyStimulus(BT_SET | BT_ALARM);
        checkLoads("time wins", 8'h11, 8'h11, 8'h11, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(BT_NEXT);
        checkOutput("time target", {ltCount[7:0], laCount[7:0]}, 16'h0201);

        // Inactivity timeout.
        applyStimulus(BT_SET);
        for (int i = 0; i < 18; i++) tick();
        checkOutput("before timeout", u_if.editing, 1'b1);
        tick();
        checkOutput("timeout idle", u_if.editing, 1'b0);
        checkOutput("timeout no pulse", {ltCount[7:0], laCount[7:0]}, 16'h0201);

        // Cancel and next in the same cycle.
        applyStimulus(BT_SET);
        driveButtons(BT_NEXT | BT_CANCEL);
        tick();
        checkOutput("cancel wins", {u_if.editing, u_if.field_sel}, 3'b000);
        driveButtons(5'b00000);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("cancel wins pulse", {ltCount[7:0], laCount[7:0]}, 16'h0201);
        checkOutput("never both", bothCount, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Button-driven setting controller that drives the alarm clock's load interface (hh_load/mm_load/ss_load/pm_load, load_time, load_alarm). On entry it snapshots the current clock time or the last committed alarm. The user steps through hours, minutes, seconds and AM/PM, incrementing each in BCD with wrap-around and auto-repeat. On completion it commits with a single-cycle load pulse; idle edits time out and are discarded.

Parameters:
REPEAT_DELAY, 500, cycles btn_inc must be held after its edge before auto-repeat starts.
REPEAT_RATE, 100, cycles between auto-repeat increments.
TIMEOUT, 10000, cycles without button activity before an edit is abandoned.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
btn_set_time  in  1  level; rising edge starts a time edit
btn_set_alarm  in  1  level; rising edge starts an alarm edit
btn_inc  in  1  level; increment current field, auto-repeat while held
btn_next  in  1  level; rising edge advances to the next field or commits
btn_cancel  in  1  level; rising edge aborts the edit
cur_hh  in  8  live clock hours, BCD 01..12
cur_mm  in  8  live clock minutes, BCD
cur_ss  in  8  live clock seconds, BCD
cur_pm  in  1  live clock PM flag
hh_load  out  8  BCD hours being edited or committed
mm_load  out  8  BCD minutes
ss_load  out  8  BCD seconds
pm_load  out  1  PM flag
load_time  out  1  one-cycle commit pulse to time registers
load_alarm  out  1  one-cycle commit pulse to alarm registers
editing  out  1  high in any EDIT_* state
field_sel  out  2  active field: 0=HH, 1=MM, 2=SS, 3=PM

Behaviour:
- Inputs are synchronous to clk. Edge detection uses a registered previous value per button.
- Reset (async, reset=0):
  - State goes to IDLE.
  - hh_load=8'h12, mm_load=8'h00, ss_load=8'h00, pm_load=0.
  - load_time=0, load_alarm=0, editing=0, field_sel=0.
  - The internal alarm shadow resets to 12:00:00 AM; the target flag resets to 0; all counters reset to 0.
  - Reset asserted mid-edit discards the edit and produces no pulse.
- States: IDLE, EDIT_HH, EDIT_MM, EDIT_SS, EDIT_PM, COMMIT.
- Leaving IDLE:
  - On a btn_set_time edge, go to EDIT_HH with target=time and copy cur_* into the load registers.
  - On a btn_set_alarm edge, go to EDIT_HH with target=alarm and copy the alarm shadow.
  - If both edges arrive in the same cycle, time wins.
  - Start buttons are ignored outside IDLE.
- In EDIT_* states, priority per cycle is cancel > next > inc; lower-priority events in that cycle are dropped.
  - cancel edge: go to IDLE with no pulse. The load registers keep their edited values (harmless, since no pulse is issued).
  - next edge: HH→MM→SS→PM→COMMIT.
  - inc increment rules:
    - HH: BCD 01..12; 12→01; 09→10.
    - MM/SS: BCD 00..59; 59→00; x9→(x+1)0.
    - PM: toggles.
    - Increments never produce invalid BCD and never carry into other fields.
- Auto-repeat:
  - The btn_inc rising edge gives one increment.
  - If btn_inc is still held after REPEAT_DELAY cycles, increment once, then once every REPEAT_RATE cycles while held.
  - Releasing btn_inc clears the repeat counter.
  - A field change resets the repeat counter. The new field does not auto-increment until btn_inc is released and pressed again.
- COMMIT lasts exactly 1 cycle:
  - Asserts load_time (target=time) or load_alarm (target=alarm) for that cycle.
  - For target=alarm, also updates the alarm shadow.
  - Returns to IDLE.
  - Load outputs are stable during the pulse and hold afterwards until the next edit start.
- editing=1 in EDIT_* states, 0 in IDLE and COMMIT. field_sel tracks the state and is 0 in IDLE.
- Timeout:
  - The counter runs in EDIT_* states and is cleared by any button edge or while btn_inc is held.
  - When it reaches TIMEOUT-1, go to IDLE with no pulse, as for cancel.
- The load pulses are never asserted together, and never more than one cycle per commit.

Test Plan:
- Reset low mid-edit, then release → IDLE, outputs 12:00:00 AM, no pulse; edit restarts only on a new set edge.
- cur=08:31:58 AM; set_time, inc×2 on HH, next, next, inc on SS, next, inc on PM, next → exactly one load_time cycle with hh_load=8'h10, mm_load=8'h31, ss_load=8'h59, pm_load=1.
- Wrap checks: HH 12 inc→01; MM 59→00; SS 09→10; PM 1→0 → exact BCD values, no carry between fields.
- REPEAT_DELAY=4, REPEAT_RATE=2; hold inc 10 cycles on MM from 00 → mm_load=8'h04 (increments at edge, +4, +6, +8 cycles); release stops increments.
- set_alarm, edit to 06:30:00 AM, commit → load_alarm only, load_time=0. A second set_alarm starts from 06:30:00 AM.
- TIMEOUT=20, no activity during edit → IDLE at cycle 20, no pulse. In a separate run, cancel and next edges in the same cycle → cancel wins, no pulse.
